// File: rtl/banked_mmu.sv
// Clocked 65xx address decoder with RAM bank register and EEPROM wait-state generator.
// Define MMU_EEPROM_WP_EN to make the wp bit block EEPROM writes and flag wp_fault.
module banked_mmu #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned BANK_W      = 4,
  parameter int unsigned EEPROM_WAIT = 2,
  parameter int unsigned DATA_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic              bus_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic              rdy,
  output logic [BANK_W-1:0] ram_bank,
  output logic              ram_ce_n,
  output logic              acia_ce_n,
  output logic              via_ce_n,
  output logic              eeprom_ce_n,
  output logic              wp_fault
);

  localparam logic       WAIT_EN    = (EEPROM_WAIT != 0);
  localparam logic [3:0] COUNT_INIT = 4'(WAIT_EN ? EEPROM_WAIT - 1 : 0);

  typedef enum logic [1:0] {StIdle, StWait, StReady} state_e;

  state_e            state_q, state_d;
  logic [3:0]        count_q, count_d;
  logic [BANK_W-1:0] bank_q;
  logic              wp_q;

  logic [2:0] region;
  logic       sub_sel;
  logic       sel_ram_fixed, sel_ram_bank, sel_acia, sel_mmu, sel_via, sel_eeprom;
  logic       access;
  logic       mmu_wr;
  logic       eeprom_block;

  // Only the top nibble of addr and a few data_in bits are decoded.
  logic unused_bits;
  assign unused_bits = ^{addr, data_in};

  assign region  = addr[ADDR_W-1 -: 3];
  assign sub_sel = addr[ADDR_W-4];

  always_comb begin
    sel_ram_fixed = (region == 3'b000);
    sel_ram_bank  = (region == 3'b001);
    sel_acia      = (region == 3'b010) && !sub_sel;
    sel_mmu       = (region == 3'b010) && sub_sel;
    sel_via       = (region == 3'b011);
    sel_eeprom    = region[2];
  end

  assign access = bus_valid && !reset;

`ifdef MMU_EEPROM_WP_EN
  assign eeprom_block = !rw && wp_q;
`else
  assign eeprom_block = 1'b0;
`endif

  // Chip enables and bank output
  always_comb begin
    ram_ce_n    = !(access && (sel_ram_fixed || sel_ram_bank));
    acia_ce_n   = !(access && sel_acia);
    via_ce_n    = !(access && sel_via);
    eeprom_ce_n = !(access && sel_eeprom && !eeprom_block);
    ram_bank    = sel_ram_bank ? bank_q : '0;
  end

  // MMU register read path
  always_comb begin
    data_oe  = access && rw && sel_mmu;
    data_out = '0;
    if (data_oe) begin
      data_out[BANK_W-1:0] = bank_q;
      data_out[DATA_W-1]   = wp_q;
    end
  end

  // count holds the wait cycles still to come, including the current one.
  // The IDLE cycle that starts an access is already the first wait cycle.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rdy     = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (WAIT_EN && access && sel_eeprom) begin
          rdy     = 1'b0;
          count_d = COUNT_INIT;
          state_d = (COUNT_INIT == 4'd0) ? StReady : StWait;
        end
      end
      StWait: begin
        rdy = 1'b0;
        if (!bus_valid) begin
          state_d = StIdle;
        end else begin
          count_d = count_q - 4'd1;
          if (count_q == 4'd1) begin
            state_d = StReady;
          end
        end
      end
      StReady: begin
        // Completion and abort both return to idle.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (reset) begin
      rdy = 1'b0;
    end
  end

  assign mmu_wr = access && rdy && !rw && sel_mmu;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
      bank_q  <= '0;
      wp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (mmu_wr) begin
        bank_q <= data_in[BANK_W-1:0];
        wp_q   <= data_in[DATA_W-1];
      end
    end
  end

`ifdef MMU_EEPROM_WP_EN
  logic wp_fault_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_fault_q <= 1'b0;
    end else if (mmu_wr) begin
      wp_fault_q <= 1'b0;
    end else if (access && rdy && sel_eeprom && eeprom_block) begin
      wp_fault_q <= 1'b1;
    end
  end

  assign wp_fault = wp_fault_q;
`else
  assign wp_fault = 1'b0;
`endif

endmodule

// File: doc/banked_mmu.md
Name: banked_mmu

Overview:
- Clocked successor to the 65xx glue-logic address decoder.
- Decodes the CPU address into active-low chip enables for RAM, ACIA, VIA and EEPROM.
- Adds a CPU-writable bank register that extends the RAM window into a larger SRAM.
- Adds a wait-state generator driving the CPU RDY line for slow EEPROM accesses.
- Sits between the CPU bus and the peripheral chip selects on the main board.

Parameters:
ADDR_W, 16, CPU address width; decode uses addr[ADDR_W-1:ADDR_W-4].
BANK_W, 4, bank register width; 2^BANK_W banks of 8 KiB in the window.
EEPROM_WAIT, 2, wait cycles inserted on EEPROM access (0 = none, max 15).
DATA_W, 8, CPU data bus width (DATA_W >= BANK_W+1).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
addr  in  ADDR_W  CPU address
rw  in  1  1 = read, 0 = write
bus_valid  in  1  access in progress; held high until completion
data_in  in  DATA_W  CPU write data
data_out  out  DATA_W  MMU register read data
data_oe  out  1  drive data_out onto bus
rdy  out  1  access may complete this cycle
ram_bank  out  BANK_W  high SRAM address bits
ram_ce_n  out  1  RAM enable
acia_ce_n  out  1  ACIA enable
via_ce_n  out  1  VIA enable
eeprom_ce_n  out  1  EEPROM enable
wp_fault  out  1  sticky write-protect violation

Behaviour:
- Reset: one clock; synchronous and active-high (clk, reset).
- Reset values:
  - bank register = 0; wp bit = 1; FSM = IDLE.
  - rdy = 0 while reset is high, 1 on the first cycle after.
  - All *_ce_n = 1; data_oe = 0; data_out = 0; wp_fault = 0.
- Decode on top three bits a = addr[ADDR_W-1:ADDR_W-3]:
  - 000: RAM fixed; ram_bank = 0.
  - 001: RAM banked window; ram_bank = bank register.
  - 010: addr[ADDR_W-4] = 0 selects ACIA; = 1 selects the MMU register (no CE).
  - 011: VIA.
  - 1xx: EEPROM.
- Chip enables:
  - Combinational decode gated by bus_valid and by !reset.
  - Exactly one CE is low at a time, or none.
  - ram_bank is combinational from addr and the bank register.
- MMU register write:
  - Occurs on the cycle with bus_valid & rdy & !rw in the MMU register region.
  - bank <= data_in[BANK_W-1:0]; wp <= data_in[DATA_W-1].
  - The new bank is visible from the next cycle.
- MMU register read:
  - Combinational during bus_valid & rw in the region: data_oe = 1.
  - data_out = {wp, zero-pad, bank}.
- Wait FSM, states IDLE / WAIT / READY, counter width 4:
  - IDLE: rdy = 1. On bus_valid & EEPROM select & EEPROM_WAIT > 0, rdy goes 0 combinationally that same cycle. Next state WAIT, count <= EEPROM_WAIT-1.
  - WAIT: rdy = 0. Count decrements; when count == 0, next state READY.
  - READY: rdy = 1. On bus_valid & rdy, next state IDLE.
  - Result: EEPROM accesses see exactly EEPROM_WAIT cycles with rdy = 0, completing on cycle EEPROM_WAIT+1.
  - bus_valid dropping in WAIT or READY aborts the access: next state IDLE, no completion.
  - EEPROM_WAIT = 0: FSM stays in IDLE; EEPROM accesses complete in 1 cycle.
  - Non-EEPROM accesses always complete in 1 cycle.
- Back-to-back accesses: a new EEPROM access starting the cycle after READY restarts the full wait.
- Reset mid-wait: state forced to IDLE and CEs forced high in the same cycle.

Optional Feature:
- Macro: MMU_EEPROM_WP_EN.
- Defined:
  - An EEPROM write (rw = 0) while wp = 1 holds eeprom_ce_n high for the whole access; the wait FSM still runs.
  - wp_fault sets on the completing cycle of such an access.
  - wp_fault clears on reset or on any MMU register write.
- Undefined:
  - wp is still stored and readable but has no effect.
  - EEPROM writes assert eeprom_ce_n normally.
  - wp_fault is tied 0.

Test Plan:
- Reset then idle: reset high 3 cycles -> all CE = 1, rdy = 0, ram_bank = 0; after release rdy = 1, data_out = 0x00 via register read returns 0x80 (wp = 1).
- Decode sweep, 1-cycle reads at 0x0000, 0x2000, 0x4000, 0x6000, 0x8000, 0xE000 -> ram, ram, acia, via, eeprom, eeprom CE low respectively; rdy = 1 each cycle.
- Bank write: write 0x05 to 0x5000, then read 0x2000 -> ram_bank = 5, ram_ce_n = 0; read 0x0000 -> ram_bank = 0; read 0x5000 -> data_out = 0x05.
- EEPROM wait, EEPROM_WAIT = 2: read 0xC000 held -> rdy = 0, 0, then 1 on the third cycle, eeprom_ce_n = 0 throughout; repeat with EEPROM_WAIT = 0 -> rdy = 1 on the first cycle.
- Abort and reset: drop bus_valid after 1 wait cycle -> FSM IDLE, next EEPROM access waits a full 2 cycles again; assert reset during WAIT -> CEs high, rdy = 0 that cycle.
- MMU_EEPROM_WP_EN: write 0x8000 with wp = 1 -> eeprom_ce_n stays 1, wp_fault = 1 after completion. Write 0x00 to 0x5000 -> wp_fault = 0; retry the write -> eeprom_ce_n = 0.
